// File: rtl/register_file_cfg_pkg.sv
// rtl/register_file_cfg_pkg.sv - shared types and default widths for the register file
// Purpose: clear-engine state encoding and default parameter values.
// Contents: rf_state_t {RF_IDLE, RF_CLEAR, RF_DONE}, RF_DATA_W, RF_ADDR_W.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_CLEAR = 2'd1,
    RF_DONE  = 2'd2
  } rf_state_t;

endpackage

// File: rtl/register_file_cfg_if.sv
// rtl/register_file_cfg_if.sv - bus bundle between decode/writeback and the register file
// Purpose: groups the write, read, clear-request and status signals.
// Ports (signals): we_i, waddr_i, wdata_i, raddr1_i, raddr2_i, clr_i (driven by master),
//   rdata1_o, rdata2_o, busy_o, clr_done_o, wr_drop_o (driven by slave).
// Modports: master (pipeline side), slave (register file side).
interface register_file_cfg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();

  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata1_o;
  logic [DATA_W-1:0] rdata2_o;
  logic              clr_i;
  logic              busy_o;
  logic              clr_done_o;
  logic              wr_drop_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr1_i, raddr2_i, clr_i,
    input  rdata1_o, rdata2_o, busy_o, clr_done_o, wr_drop_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr1_i, raddr2_i, clr_i,
    output rdata1_o, rdata2_o, busy_o, clr_done_o, wr_drop_o
  );

endinterface

// File: rtl/register_file_cfg_clear_fsm.sv
// rtl/register_file_cfg_clear_fsm.sv - sequenced clear engine, one register per cycle
// Purpose: walks a pointer from 0 to DEPTH-1, then signals completion for one cycle.
// Ports: clk, reset (async, active-high), clr_i (start request, honoured in idle only),
//   clear_en / clear_addr (zero this register on the coming edge), busy, done.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  output logic              clear_en,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  rf_state_t         state;
  logic [ADDR_W-1:0] ptr;

  assign clear_addr = ptr;

  // Outputs are registered alongside the state so they change only on edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RF_IDLE;
      ptr      <= '0;
      clear_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        RF_IDLE: begin
          if (clr_i) begin
            state    <= RF_CLEAR;
            ptr      <= '0;
            clear_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RF_CLEAR: begin
          // Pointer parks on the last address rather than wrapping to 0.
          if (ptr == LAST_ADDR) begin
            state    <= RF_DONE;
            clear_en <= 1'b0;
            done     <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        RF_DONE: begin
          state <= RF_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state    <= RF_IDLE;
          clear_en <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file_cfg.sv
// rtl/register_file_cfg.sv - 1W/2R register file with clear engine and optional forwarding
// Purpose: storage array, write decode, two combinational read ports, sweep-clear control.
// Ports: clk, reset (async, active-high), rf (register_file_cfg_if.slave: write port,
//   two read ports, clr_i request, busy_o / clr_done_o / wr_drop_o status).
// Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), ZERO_REG (register 0 hardwired to zero).
// Build option: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module register_file_cfg
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  register_file_cfg_if.slave  rf
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              clear_en;
  logic [ADDR_W-1:0] clear_addr;
  logic              busy;
  logic              done;
  logic              wr_commit;

  rf_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (rf.clr_i),
    .clear_en   (clear_en),
    .clear_addr (clear_addr),
    .busy       (busy),
    .done       (done)
  );

  // A write to the hardwired zero register is silently ignored, not flagged as dropped.
  assign wr_commit = rf.we_i && !busy && !((ZERO_REG != 0) && (rf.waddr_i == '0));

  assign rf.busy_o     = busy;
  assign rf.clr_done_o = done;
  assign rf.wr_drop_o  = rf.we_i & busy;

  // Writes only commit while idle and the sweep only runs while busy, so the two never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (clear_en) begin
      regs[clear_addr] <= '0;
    end else if (wr_commit) begin
      regs[rf.waddr_i] <= rf.wdata_i;
    end
  end

  always_comb begin
    rf.rdata1_o = regs[rf.raddr1_i];
    rf.rdata2_o = regs[rf.raddr2_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_commit && (rf.raddr1_i == rf.waddr_i)) rf.rdata1_o = rf.wdata_i;
    if (wr_commit && (rf.raddr2_i == rf.waddr_i)) rf.rdata2_o = rf.wdata_i;
`endif
    if ((ZERO_REG != 0) && (rf.raddr1_i == '0)) rf.rdata1_o = '0;
    if ((ZERO_REG != 0) && (rf.raddr2_i == '0)) rf.rdata2_o = '0;
  end

endmodule

// File: tb/tb_register_file_cfg.sv
// tb/tb_register_file_cfg.sv - self-checking bench for register_file_cfg
module tb_register_file_cfg;

  logic clk = 1'b0;
  logic reset;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mdl [32];
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  register_file_cfg_if #(.DATA_W(32), .ADDR_W(5)) rf_bus ();

  register_file_cfg #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    rf_bus.we_i    = 1'b1;
    rf_bus.waddr_i = a;
    rf_bus.wdata_i = d;
    tick();
    rf_bus.we_i = 1'b0;
    if (a != 5'd0) mdl[a] = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rf_bus.we_i = 0; rf_bus.waddr_i = 0; rf_bus.wdata_i = 0;
    rf_bus.raddr1_i = 0; rf_bus.raddr2_i = 0; rf_bus.clr_i = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front(); vectors++;
    if ({31'd0, rf_bus.busy_o} !== exp_v) begin
      miscompares++; $display("FAIL reset_busy got %0h exp %0h", rf_bus.busy_o, exp_v);
    end
    exp_v = exp_q.pop_front(); vectors++;
    if ({31'd0, rf_bus.clr_done_o} !== exp_v) begin
      miscompares++; $display("FAIL reset_done got %0h exp %0h", rf_bus.clr_done_o, exp_v);
    end
    exp_v = exp_q.pop_front(); vectors++;
    if ({31'd0, rf_bus.wr_drop_o} !== exp_v) begin
      miscompares++; $display("FAIL reset_wr_drop got %0h exp %0h", rf_bus.wr_drop_o, exp_v);
    end
    for (int i = 0; i < 32; i++) begin
      rf_bus.raddr1_i = 5'(i);
      rf_bus.raddr2_i = 5'(31 - i);
      #1;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); vectors++;
      if (rf_bus.rdata1_o !== exp_v) begin
        miscompares++; $display("FAIL reset_rd1[%0d] got %h exp %h", i, rf_bus.rdata1_o, exp_v);
      end
      exp_v = exp_q.pop_front(); vectors++;
      if (rf_bus.rdata2_o !== exp_v) begin
        miscompares++; $display("FAIL reset_rd2[%0d] got %h exp %h", 31 - i, rf_bus.rdata2_o, exp_v);
      end
    end
  endtask

  task automatic test_write_read;
    do_write(5'd5, 32'hDEADBEEF);
    do_write(5'd9, 32'h0BADF00D);
    rf_bus.raddr1_i = 5'd5; rf_bus.raddr2_i = 5'd5;
    #1;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
    exp_v = exp_q.pop_front(); vectors++;
    if (rf_bus.rdata1_o !== exp_v) begin
      miscompares++; $display("FAIL wr_rd1_r5 got %h exp %h", rf_bus.rdata1_o, exp_v);
    end
    exp_v = exp_q.pop_front(); vectors++;
    if (rf_bus.rdata2_o !== exp_v) begin
      miscompares++; $display("FAIL wr_rd2_r5 got %h exp %h", rf_bus.rdata2_o, exp_v);
    end
    rf_bus.raddr2_i = 5'd9;
    #1;
    exp_q.push_back(32'h0BADF00D);
    exp_v = exp_q.pop_front(); vectors++;
    if (rf_bus.rdata2_o !== exp_v) begin
      miscompares++; $display("FAIL wr_rd2_r9 got %h exp %h", rf_bus.rdata2_o, exp_v);
    end
  endtask

  task automatic test_zero_reg;
    rf_bus.we_i = 1'b1; rf_bus.waddr_i = 5'd0; rf_bus.wdata_i = 32'h12345678;
    rf_bus.raddr1_i = 5'd0; rf_bus.raddr2_i = 5'd0;
    #1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front(); vectors++;
    if (rf_bus.rdata1_o !== exp_v) begin
      miscompares++; $display("FAIL zero_same_cycle got %h exp %h", rf_bus.rdata1_o, exp_v);
    end
    exp_v = exp_q.pop_front(); vectors++;
    if ({31'd0, rf_bus.wr_drop_o} !== exp_v) begin
      miscompares++; $display("FAIL zero_wr_drop got %0h exp %0h", rf_bus.wr_drop_o, exp_v);
    end
    tick();
    rf_bus.we_i = 1'b0;
    #1;
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front(); vectors++;
    if (rf_bus.rdata2_o !== exp_v) begin
      miscompares++; $display("FAIL zero_after got %h exp %h", rf_bus.rdata2_o, exp_v);
    end
  endtask

  task automatic test_same_cycle;
    do_write(5'd7, 32'h00000011);
    rf_bus.we_i = 1'b1; rf_bus.waddr_i = 5'd7; rf_bus.wdata_i = 32'hA5A5A5A5;
    rf_bus.raddr1_i = 5'd7; rf_bus.raddr2_i = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hA5A5A5A5);
`else
    exp_q.push_back(32'h00000011);
`endif
    exp_q.push_back(mdl[5]);
    exp_v = exp_q.pop_front(); vectors++;
    if (rf_bus.rdata1_o !== exp_v) begin
      miscompares++; $display("FAIL same_cycle_rd1 got %h exp %h", rf_bus.rdata1_o, exp_v);
    end
    exp_v = exp_q.pop_front(); vectors++;
    if (rf_bus.rdata2_o !== exp_v) begin
      miscompares++; $display("FAIL same_cycle_rd2_other got %h exp %h", rf_bus.rdata2_o, exp_v);
    end
    tick();
    rf_bus.we_i = 1'b0;
    mdl[7] = 32'hA5A5A5A5;
    #1;
    exp_q.push_back(32'hA5A5A5A5);
    exp_v = exp_q.pop_front(); vectors++;
    if (rf_bus.rdata1_o !== exp_v) begin
      miscompares++; $display("FAIL same_cycle_next got %h exp %h", rf_bus.rdata1_o, exp_v);
    end
  endtask

  task automatic test_clear_sweep;
    int busy_cycles = 0;
    int done_cycle = 0;
    int done_count = 0;
    for (int a = 1; a < 32; a++) do_write(5'(a), 32'(a));
    rf_bus.clr_i = 1'b1;
    tick();
    rf_bus.clr_i = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 5) begin
        rf_bus.we_i = 1'b1; rf_bus.waddr_i = 5'd2; rf_bus.wdata_i = 32'h77;
      end
      if (cyc == 10) begin
        rf_bus.raddr1_i = 5'd5; rf_bus.raddr2_i = 5'd20;
      end
      if (cyc == 20) rf_bus.clr_i = 1'b1;
      #1;
      if (cyc == 5) begin
        exp_q.push_back(32'd1);
        exp_v = exp_q.pop_front(); vectors++;
        if ({31'd0, rf_bus.wr_drop_o} !== exp_v) begin
          miscompares++; $display("FAIL sweep_wr_drop got %0h exp %0h", rf_bus.wr_drop_o, exp_v);
        end
      end
      if (cyc == 10) begin
        exp_q.push_back(32'd0); exp_q.push_back(32'd20);
        exp_v = exp_q.pop_front(); vectors++;
        if (rf_bus.rdata1_o !== exp_v) begin
          miscompares++; $display("FAIL sweep_live_r5 got %h exp %h", rf_bus.rdata1_o, exp_v);
        end
        exp_v = exp_q.pop_front(); vectors++;
        if (rf_bus.rdata2_o !== exp_v) begin
          miscompares++; $display("FAIL sweep_live_r20 got %h exp %h", rf_bus.rdata2_o, exp_v);
        end
      end
      if (rf_bus.busy_o === 1'b1) busy_cycles++;
      if (rf_bus.clr_done_o === 1'b1) begin
        done_count++;
        if (done_cycle == 0) done_cycle = cyc;
      end
      tick();
      rf_bus.we_i = 1'b0; rf_bus.clr_i = 1'b0;
    end
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    exp_q.push_back(32'd33); exp_q.push_back(32'd33); exp_q.push_back(32'd1);
    exp_v = exp_q.pop_front(); vectors++;
    if (32'(busy_cycles) !== exp_v) begin
      miscompares++; $display("FAIL sweep_busy_cycles got %0d exp %0d", busy_cycles, exp_v);
    end
    exp_v = exp_q.pop_front(); vectors++;
    if (32'(done_cycle) !== exp_v) begin
      miscompares++; $display("FAIL sweep_done_cycle got %0d exp %0d", done_cycle, exp_v);
    end
    exp_v = exp_q.pop_front(); vectors++;
    if (32'(done_count) !== exp_v) begin
      miscompares++; $display("FAIL sweep_done_count got %0d exp %0d", done_count, exp_v);
    end
    for (int i = 0; i < 32; i++) begin
      rf_bus.raddr1_i = 5'(i);
      #1;
      exp_q.push_back(mdl[i]);
      exp_v = exp_q.pop_front(); vectors++;
      if (rf_bus.rdata1_o !== exp_v) begin
        miscompares++; $display("FAIL sweep_cleared[%0d] got %h exp %h", i, rf_bus.rdata1_o, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    int busy_seen = 0;
    int done_seen = 0;
    // Write and sweep request in the same idle cycle: the write must land first.
    rf_bus.we_i = 1'b1; rf_bus.waddr_i = 5'd20; rf_bus.wdata_i = 32'd20; rf_bus.clr_i = 1'b1;
    tick();
    rf_bus.we_i = 1'b0; rf_bus.clr_i = 1'b0;
    rf_bus.raddr1_i = 5'd20;
    #1;
    exp_q.push_back(32'd20);
    exp_v = exp_q.pop_front(); vectors++;
    if (rf_bus.rdata1_o !== exp_v) begin
      miscompares++; $display("FAIL clr_we_same_cycle got %h exp %h", rf_bus.rdata1_o, exp_v);
    end
    repeat (9) tick();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(mdl[20]);
    exp_v = exp_q.pop_front(); vectors++;
    if ({31'd0, rf_bus.busy_o} !== exp_v) begin
      miscompares++; $display("FAIL midreset_busy got %0h exp %0h", rf_bus.busy_o, exp_v);
    end
    exp_v = exp_q.pop_front(); vectors++;
    if ({31'd0, rf_bus.clr_done_o} !== exp_v) begin
      miscompares++; $display("FAIL midreset_done got %0h exp %0h", rf_bus.clr_done_o, exp_v);
    end
    exp_v = exp_q.pop_front(); vectors++;
    if (rf_bus.rdata1_o !== exp_v) begin
      miscompares++; $display("FAIL midreset_r20 got %h exp %h", rf_bus.rdata1_o, exp_v);
    end
    tick();
    reset = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (rf_bus.busy_o !== 1'b0) busy_seen++;
      if (rf_bus.clr_done_o !== 1'b0) done_seen++;
      tick();
    end
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front(); vectors++;
    if (32'(busy_seen) !== exp_v) begin
      miscompares++; $display("FAIL midreset_busy_after got %0d exp %0d", busy_seen, exp_v);
    end
    exp_v = exp_q.pop_front(); vectors++;
    if (32'(done_seen) !== exp_v) begin
      miscompares++; $display("FAIL midreset_no_done got %0d exp %0d", done_seen, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_same_cycle();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
